// File: rtl/muldiv_unit.sv
// Iterative MIPS multiply/divide unit owning the HI/LO register pair.
// Define MULDIV_FAST_MUL_EN to replace the shift-add multiplier with a single-cycle one.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clk_enable,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]      CNT_INIT = CW'(WIDTH);
  localparam logic [CW-1:0]      CNT_ONE  = CW'(1);
  localparam logic [WIDTH-1:0]   ZERO_W   = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0]   ONES_W   = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0]   ONE_W    = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [2*WIDTH-1:0] ONE_2W   = {{(2*WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_FIXUP = 2'd2} state_t;

  function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v);
    return (~v) + ONE_W;
  endfunction

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opb_q, opb_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic               busy_q, busy_d, done_q, done_d;
  logic               is_div_q, is_div_d, neg_res_q, neg_res_d;
  logic               neg_rem_q, neg_rem_d, div_zero_q, div_zero_d;

  logic               signed_op, rs_neg, rt_neg;
  logic [WIDTH-1:0]   rs_mag, rt_mag, quo_fix, rem_fix;
  logic [WIDTH:0]     mul_sum, div_trial;
  logic [2*WIDTH-1:0] prod_fix;

  // Operand magnitudes, one iteration step of each algorithm, and final sign correction
  always_comb begin
    signed_op = ~op[0] & ~op[2];
    rs_neg    = signed_op & rs_data[WIDTH-1];
    rt_neg    = signed_op & rt_data[WIDTH-1];
    rs_mag    = rs_neg ? neg_w(rs_data) : rs_data;
    rt_mag    = rt_neg ? neg_w(rt_data) : rt_data;
    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? opb_q : ZERO_W)};
    div_trial = acc_q[2*WIDTH-1:WIDTH-1] - {1'b0, opb_q};
    prod_fix  = neg_res_q ? ((~acc_q) + ONE_2W) : acc_q;
    // A zero divisor leaves the dividend magnitude in the remainder half, so the
    // remainder sign fix restores the original dividend
    if (div_zero_q) begin
      quo_fix = ONES_W;
    end else begin
      quo_fix = neg_res_q ? neg_w(acc_q[WIDTH-1:0]) : acc_q[WIDTH-1:0];
    end
    rem_fix = neg_rem_q ? neg_w(acc_q[2*WIDTH-1:WIDTH]) : acc_q[2*WIDTH-1:WIDTH];
  end

  // Next-state logic for the IDLE/RUN/FIXUP sequencer and HI/LO
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    opb_d      = opb_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    is_div_d   = is_div_q;
    neg_res_d  = neg_res_q;
    neg_rem_d  = neg_rem_q;
    div_zero_d = div_zero_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          case (op)
            3'd0, 3'd1, 3'd2, 3'd3: begin
              is_div_d   = op[1];
              neg_res_d  = rs_neg ^ rt_neg;
              neg_rem_d  = rs_neg;
              div_zero_d = op[1] & (rt_data == ZERO_W);
              busy_d     = 1'b1;
              cnt_d      = CNT_INIT;
              if (op[1]) begin
                opb_d   = rt_mag;
                acc_d   = {ZERO_W, rs_mag};
                state_d = S_RUN;
              end else begin
                opb_d   = rs_mag;
`ifdef MULDIV_FAST_MUL_EN
                acc_d   = {ZERO_W, rs_mag} * {ZERO_W, rt_mag};
                state_d = S_FIXUP;
`else
                acc_d   = {ZERO_W, rt_mag};
                state_d = S_RUN;
`endif
              end
            end
            3'd4:    hi_d = rs_data;
            3'd5:    lo_d = rs_data;
            default: state_d = S_IDLE;
          endcase
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        if (is_div_q) begin
          if (!div_trial[WIDTH]) begin
            acc_d = {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
          end else begin
            acc_d = {acc_q[2*WIDTH-2:0], 1'b0};
          end
        end else begin
          acc_d = {mul_sum, acc_q[WIDTH-1:1]};
        end
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          state_d = S_FIXUP;
        end else begin
          state_d = S_RUN;
        end
      end
      S_FIXUP: begin
        if (is_div_q) begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end else begin
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // State register: reset wins over the stall gate
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= {CW{1'b0}};
      acc_q      <= {ZERO_W, ZERO_W};
      opb_q      <= ZERO_W;
      hi_q       <= ZERO_W;
      lo_q       <= ZERO_W;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      is_div_q   <= 1'b0;
      neg_res_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      div_zero_q <= 1'b0;
    end else if (clk_enable) begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      opb_q      <= opb_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      is_div_q   <= is_div_d;
      neg_res_q  <= neg_res_d;
      neg_rem_q  <= neg_rem_d;
      div_zero_q <= div_zero_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: expected {hi,lo} queued at start, checked at done.
module tb_muldiv_unit;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        clk_enable = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  op = 3'd7;
  logic [31:0] rs_data = 32'd0;
  logic [31:0] rt_data = 32'd0;
  logic        busy, done;
  logic [31:0] hi, lo;

  int n_cmp = 0;
  int n_err = 0;
  logic [63:0] sb[$];

`ifdef MULDIV_FAST_MUL_EN
  localparam int LAT_MUL = 1;
`else
  localparam int LAT_MUL = 33;
`endif
  localparam int LAT_DIV = 33;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .clk_enable(clk_enable), .start(start), .op(op),
    .rs_data(rs_data), .rt_data(rt_data), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb2;
    logic [63:0] r;
    sa  = longint'($signed(a));
    sb2 = longint'($signed(b));
    case (o)
      3'd0: r = 64'(sa * sb2);
      3'd1: r = {32'd0, a} * {32'd0, b};
      3'd2: r = (b == 32'd0) ? {a, 32'hFFFF_FFFF} : {32'(sa % sb2), 32'(sa / sb2)};
      3'd3: r = (b == 32'd0) ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
      default: r = 64'd0;
    endcase
    return r;
  endfunction

  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] exp_val, input int lat, input int poke_at,
                        input int stall_at, input int stall_len, input string name);
    logic [31:0] hi0, lo0;
    logic [63:0] want;
    int en_cyc, wall, guard;
    bit stable;
    hi0 = hi; lo0 = lo; stable = 1'b1;
    sb.push_back(exp_val);
    start = 1'b1; op = o; rs_data = a; rt_data = b;
    step();
    start = 1'b0; op = 3'd7; rs_data = $urandom; rt_data = $urandom;
    n_cmp++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      n_err++; $display("FAIL %s_issue: busy/done got %b%b want 10", name, busy, done);
    end
    en_cyc = 1; wall = 1; guard = 0;
    while (busy === 1'b1 && guard < 500) begin
      if (hi !== hi0 || lo !== lo0) stable = 1'b0;
      if (en_cyc == poke_at) begin
        start = 1'b1; op = 3'd1; rs_data = 32'h0000_0005; rt_data = 32'h0000_0007;
      end
      if (en_cyc == stall_at && stall_len > 0) begin
        clk_enable = 1'b0;
        repeat (stall_len) begin
          step();
          if (busy === 1'b1) wall++;
          if (done !== 1'b0 || hi !== hi0 || lo !== lo0) stable = 1'b0;
        end
        clk_enable = 1'b1;
      end
      step();
      start = 1'b0; op = 3'd7;
      guard++;
      if (busy === 1'b1) begin
        en_cyc++; wall++;
      end
    end
    n_cmp++;
    if (guard >= 500) begin
      n_err++; $display("FAIL %s_timeout: busy still %b after %0d cycles, want 0", name, busy, guard);
    end
    n_cmp++;
    if (en_cyc !== lat) begin
      n_err++; $display("FAIL %s_busy_len: got %0d enabled cycles want %0d", name, en_cyc, lat);
    end
    n_cmp++;
    if (wall !== lat + stall_len) begin
      n_err++; $display("FAIL %s_wall_len: got %0d cycles want %0d", name, wall, lat + stall_len);
    end
    n_cmp++;
    if (stable !== 1'b1) begin
      n_err++; $display("FAIL %s_hilo_stable: got %b want 1", name, stable);
    end
    n_cmp++;
    if (done !== 1'b1) begin
      n_err++; $display("FAIL %s_done: got %b want 1", name, done);
    end
    n_cmp++;
    if (sb.size() == 0) begin
      n_err++; $display("FAIL %s_scoreboard: got empty queue want 1 entry", name);
    end else begin
      want = sb.pop_front();
      if ({hi, lo} !== want) begin
        n_err++; $display("FAIL %s_result: hi/lo got %h want %h", name, {hi, lo}, want);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; clk_enable = 1'b0;
    repeat (2) step();
    n_cmp++;
    if ({busy, done, hi, lo} !== 66'd0) begin
      n_err++; $display("FAIL reset_state: busy/done/hi/lo got %b %b %h %h want all 0", busy, done, hi, lo);
    end
    reset = 1'b0; clk_enable = 1'b1;
    step();
  endtask

  task automatic test_multu();
    run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, LAT_MUL, 0, 0, 0, "multu_max");
    step();
    n_cmp++;
    if (done !== 1'b0) begin
      n_err++; $display("FAIL multu_done_pulse: got %b want 0", done);
    end
  endtask

  task automatic test_mult();
    run_op(3'd0, 32'hFFFF_FFFD, 32'h0000_0007, 64'hFFFF_FFFF_FFFF_FFEB, LAT_MUL, 0, 0, 0, "mult_neg");
  endtask

  task automatic test_div();
    run_op(3'd2, 32'hFFFF_FFF9, 32'h0000_0002, 64'hFFFF_FFFF_FFFF_FFFD, LAT_DIV, 0, 0, 0, "div_neg");
    run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, LAT_DIV, 0, 0, 0, "div_ovf");
  endtask

  task automatic test_divu_zero();
    run_op(3'd3, 32'd100, 32'd0, 64'h0000_0064_FFFF_FFFF, LAT_DIV, 5, 0, 0, "divu_zero");
    step();
    n_cmp++;
    if (done !== 1'b0 || busy !== 1'b0 || {hi, lo} !== 64'h0000_0064_FFFF_FFFF) begin
      n_err++; $display("FAIL divu_poke_ignored: busy/done/hi/lo got %b %b %h %h want 0 0 00000064 ffffffff",
                        busy, done, hi, lo);
    end
  endtask

  task automatic test_mthi_mtlo();
    logic [31:0] lo0;
    lo0 = lo;
    start = 1'b1; op = 3'd4; rs_data = 32'h1234_5678;
    step();
    start = 1'b0; op = 3'd7;
    n_cmp++;
    if (hi !== 32'h1234_5678 || lo !== lo0 || busy !== 1'b0 || done !== 1'b0) begin
      n_err++; $display("FAIL mthi: hi/lo/busy/done got %h %h %b %b want 12345678 %h 0 0", hi, lo, busy, done, lo0);
    end
    start = 1'b1; op = 3'd5; rs_data = 32'h9ABC_DEF0;
    step();
    start = 1'b0; op = 3'd7;
    n_cmp++;
    if (hi !== 32'h1234_5678 || lo !== 32'h9ABC_DEF0 || busy !== 1'b0 || done !== 1'b0) begin
      n_err++; $display("FAIL mtlo: hi/lo/busy/done got %h %h %b %b want 12345678 9abcdef0 0 0", hi, lo, busy, done);
    end
    step();
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_err++; $display("FAIL mthi_mtlo_idle: busy/done got %b %b want 0 0", busy, done);
    end
  endtask

  task automatic test_stall();
    int at;
    at = (LAT_MUL > 1) ? 10 : 1;
    run_op(3'd1, 32'h0001_2345, 32'h000A_BCDE, model(3'd1, 32'h0001_2345, 32'h000A_BCDE),
           LAT_MUL, 0, at, 5, "multu_stall");
  endtask

  task automatic test_reset_abort();
    bit saw_done;
    saw_done = 1'b0;
    start = 1'b1; op = 3'd2; rs_data = 32'd1000; rt_data = 32'd7;
    step();
    start = 1'b0; op = 3'd7;
    repeat (9) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    n_cmp++;
    if ({busy, done, hi, lo} !== 66'd0) begin
      n_err++; $display("FAIL abort_state: busy/done/hi/lo got %b %b %h %h want all 0", busy, done, hi, lo);
    end
    repeat (40) begin
      step();
      if (done !== 1'b0 || busy !== 1'b0) saw_done = 1'b1;
    end
    n_cmp++;
    if (saw_done !== 1'b0) begin
      n_err++; $display("FAIL abort_quiet: activity after reset got %b want 0", saw_done);
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0]  o;
    logic [31:0] a, b;
    for (int i = 0; i < 6; i++) begin
      o = 3'($urandom_range(0, 3));
      a = $urandom;
      b = (i == 2) ? 32'd0 : ((i == 4) ? 32'($urandom_range(1, 50)) : $urandom);
      if (i == 2) o = 3'd2;
      run_op(o, a, b, model(o, a, b), o[1] ? LAT_DIV : LAT_MUL, 0, 0, 0, "b2b");
    end
  endtask

  initial begin
    test_reset();
    test_multu();
    test_mult();
    test_div();
    test_divu_zero();
    test_mthi_mtlo();
    test_stall();
    test_reset_abort();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
